pwm_duty_sequencer: RTL and testbench
=====================================

# pwm_duty_sequencer

Command-driven controller that generates the `duty` input of a downstream 4-bit PWM generator. It steps `duty` over time to a target value, either at once, as a linear ramp, or as a continuous triangle "breathe" between 0 and a peak. It sits between a control source (CPU register bank or button FSM) and the PWM datapath, and owns all duty changes for one PWM channel.

## Interface
- `DUTY_W`, 4: duty width; must match the PWM duty width.
- `RATE_W`, 16: width of the step-interval field.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_mode`  in  2  00 SET, 01 RAMP, 10 BREATHE, 11 STOP.
- `cmd_target`  in  DUTY_W  target duty (RAMP/SET) or peak (BREATHE).
- `cmd_rate`  in  RATE_W  step interval R: one step per R+1 cycles.
- `abort`  in  1  synchronous force-to-zero, priority over commands.
- `duty`  out  DUTY_W  registered duty to PWM.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse: SET/RAMP/STOP completed.
- `wrap`  out  1  one-cycle pulse: breathe returned to duty 0.

## Operation
- States: IDLE, RAMP, BREATHE_UP, BREATHE_DN.
- `cmd_ready` = 1 in IDLE, BREATHE_UP, BREATHE_DN; 0 in RAMP. Accept = `cmd_valid & cmd_ready`. An accepted command preempts breathing.
- On accept, latch `target_q` = cmd_target and `rate_q` = cmd_rate, and clear the tick counter.
- Tick counter `tcnt` (RATE_W bits): `tick` = (tcnt == rate_q). On tick, tcnt goes to 0; otherwise it increments. It runs only in RAMP and BREATHE_*. With R = 0, a tick occurs every cycle.
- SET: duty <= target, state IDLE, done = 1.
- STOP: duty <= 0, state IDLE, done = 1.
- RAMP:
  - If duty == target at accept, behave as SET.
  - Otherwise enter RAMP. On each tick, duty moves ±1 toward target_q.
  - The edge where duty reaches target_q also sets state IDLE and done = 1.
  - No overshoot. Arithmetic never wraps.
- BREATHE:
  - If peak == 0, behave as STOP but with done = 0.
  - Otherwise enter BREATHE_DN if duty > peak, else BREATHE_UP.
  - UP: on tick, duty+1. The step that reaches peak also switches to DN.
  - DN: on tick, duty−1. The step that reaches 0 also switches to UP and pulses `wrap`.
  - Breathing never pulses done. It runs until the next command or abort.
  - Steady period = 2·peak·(R+1) cycles.
- `abort` = 1 in any state: duty <= 0, state IDLE, tcnt <= 0, done = 0, wrap = 0. Any command presented in that cycle is not accepted: `cmd_ready` is forced 0 while abort = 1.
- `duty` changes only on the edges listed above. It holds its value in IDLE.

## Timing
- Reset (reset = 0): duty = 0, state IDLE, busy = 0, done = 0, wrap = 0, tcnt = 0, target_q = 0, rate_q = 0. `cmd_ready` = 1 once abort = 0.
- All outputs except `cmd_ready` are registered. `cmd_ready` is combinational from state and abort.
- SET/STOP accepted at edge T: new duty and the done pulse are visible in the cycle after T.
- RAMP accepted at edge T with interval R: the k-th step lands on edge T + k·(R+1).
- `done` and `wrap` are high for exactly one cycle, on the same edge as the final or zero-reaching duty update.
- Reset asserted mid-operation clears everything immediately (asynchronous). Release is synchronous to `clk`.

## Test plan
- Reset: hold reset = 0 with random inputs. Required: duty = 0, busy = 0, done = 0, wrap = 0, cmd_ready = 1.
- SET 9: accept at T. Required: duty = 9 and done = 1 for one cycle after T, busy = 0. A following SET 9 also gives an immediate done.
- RAMP 9→12, R = 2:
  - Required: duty 10/11/12 at T+3/T+6/T+9, done with 12, cmd_ready = 0 for cycles T+1..T+9.
  - A cmd_valid pulse presented mid-ramp is ignored.
- RAMP 12→0, R = 0: duty decrements every cycle, 12 steps, done on 0, no underflow.
- BREATHE peak 3, R = 0, from 0:
  - Required duty sequence: 1,2,3,2,1,0,1,…; wrap pulses on each 0; period 6 cycles.
  - SET 5 issued mid-breathe: accepted immediately, duty = 5, done.
- Abort mid-RAMP (duty 7) with cmd_valid high: duty 0 next cycle, IDLE, no done, command not accepted. Then reset = 0 during BREATHE: outputs clear asynchronously.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
// Duty-cycle sequencer for one 4-bit PWM channel: immediate set, linear ramp,
// or continuous triangle "breathe" between 0 and a peak, paced by a tick counter.
module pwm_duty_sequencer #(
    parameter int unsigned DUTY_W = 4,
    parameter int unsigned RATE_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [RATE_W-1:0] cmd_rate,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              done,
    output logic              wrap
);

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_SET     = 2'b00,
        MODE_RAMP    = 2'b01,
        MODE_BREATHE = 2'b10,
        MODE_STOP    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RAMP    = 2'd1,
        S_BRE_UP  = 2'd2,
        S_BRE_DN  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic [DUTY_W-1:0]   target_q, target_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic [RATE_W-1:0]   tcnt_q, tcnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wrap_q, wrap_d;

    logic                tick_c;
    logic                accept_c;
    logic [DUTY_W-1:0]   duty_inc_c;
    logic [DUTY_W-1:0]   duty_dec_c;
    mode_e               mode_c;

    // Ready is the only combinational output: blocked while ramping or aborting.
    assign cmd_ready  = (state_q != S_RAMP) && !abort;
    assign accept_c   = cmd_valid && cmd_ready;
    assign tick_c     = (tcnt_q == rate_q);
    assign duty_inc_c = duty_q + DUTY_W'(1);
    assign duty_dec_c = duty_q - DUTY_W'(1);
    assign mode_c     = mode_e'(cmd_mode);

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        rate_d   = rate_q;
        tcnt_d   = tcnt_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;

        if (state_q != S_IDLE) begin
            tcnt_d = tick_c ? '0 : tcnt_q + RATE_W'(1);
        end

        // Stepping toward the target; steps only ever move toward a bound, so no wrap.
        case (state_q)
            S_RAMP: begin
                if (tick_c) begin
                    if (duty_q < target_q) begin
                        duty_d = duty_inc_c;
                        if (duty_inc_c == target_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else if (duty_q > target_q) begin
                        duty_d = duty_dec_c;
                        if (duty_dec_c == target_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_BRE_UP: begin
                if (tick_c) begin
                    if (duty_q >= target_q) begin
                        state_d = S_BRE_DN;
                    end else begin
                        duty_d = duty_inc_c;
                        if (duty_inc_c == target_q) begin
                            state_d = S_BRE_DN;
                        end
                    end
                end
            end
            S_BRE_DN: begin
                if (tick_c) begin
                    if (duty_q == '0) begin
                        state_d = S_BRE_UP;
                    end else begin
                        duty_d = duty_dec_c;
                        if (duty_dec_c == '0) begin
                            state_d = S_BRE_UP;
                            wrap_d  = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase

        // A new command overrides any step in progress, including breathing.
        if (accept_c) begin
            target_d = cmd_target;
            rate_d   = cmd_rate;
            tcnt_d   = '0;
            wrap_d   = 1'b0;
            done_d   = 1'b0;
            case (mode_c)
                MODE_SET: begin
                    duty_d  = cmd_target;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
                MODE_RAMP: begin
                    if (duty_q == cmd_target) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RAMP;
                    end
                end
                MODE_BREATHE: begin
                    if (cmd_target == '0) begin
                        duty_d  = '0;
                        state_d = S_IDLE;
                    end else if (duty_q > cmd_target) begin
                        state_d = S_BRE_DN;
                    end else begin
                        state_d = S_BRE_UP;
                    end
                end
                default: begin
                    duty_d  = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            endcase
        end

        if (abort) begin
            state_d = S_IDLE;
            duty_d  = '0;
            tcnt_d  = '0;
            done_d  = 1'b0;
            wrap_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            duty_q   <= '0;
            target_q <= '0;
            rate_q   <= '0;
            tcnt_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            rate_q   <= rate_d;
            tcnt_q   <= tcnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    assign duty = duty_q;
    assign busy = busy_q;
    assign done = done_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: a per-cycle check against a closed-form
// model (duty as a function of time since the command) plus literal spot checks.
module tb_pwm_duty_sequencer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [3:0]  cmd_target;
    logic [15:0] cmd_rate;
    logic        abort;
    logic [3:0]  duty;
    logic        busy;
    logic        done;
    logic        wrap;

    pwm_duty_sequencer #(.DUTY_W(4), .RATE_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_target (cmd_target),
        .cmd_rate   (cmd_rate),
        .abort      (abort),
        .duty       (duty),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap)
    );

    localparam logic [1:0] M_SET = 2'b00, M_RAMP = 2'b01, M_BRE = 2'b10, M_STOP = 2'b11;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: 0 = holding, 1 = ramp, 2 = breathe; outputs derived from elapsed time.
    int cyc     = 0;
    int kind    = 0;
    int t0      = 0;
    int d0      = 0;
    int tgt     = 0;
    int r1      = 1;
    int hold    = 0;
    int done_at = -1;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int tri_wave(input int p, input int pk);
        int q;
        q = p % (2 * pk);
        return (q <= pk) ? q : 2 * pk - q;
    endfunction

    function automatic int m_duty();
        int e, n, s;
        e = cyc - t0;
        n = e / r1;
        if (kind == 1) begin
            s = (n < iabs(tgt - d0)) ? n : iabs(tgt - d0);
            return (tgt > d0) ? d0 + s : d0 - s;
        end else if (kind == 2) begin
            if (d0 > tgt) return (n <= d0) ? d0 - n : tri_wave(n - d0, tgt);
            return tri_wave(d0 + n, tgt);
        end
        return hold;
    endfunction

    function automatic bit m_ramping();
        return (kind == 1) && ((cyc - t0) < iabs(tgt - d0) * r1);
    endfunction

    function automatic bit m_busy();
        return m_ramping() || (kind == 2);
    endfunction

    function automatic bit m_done();
        if (kind == 1) return (cyc - t0) == iabs(tgt - d0) * r1;
        return (kind == 0) && (cyc == done_at);
    endfunction

    function automatic bit m_wrap();
        int e;
        e = cyc - t0;
        return (kind == 2) && (e > 0) && (e % r1 == 0) && (m_duty() == 0);
    endfunction

    // Model update at each active edge from the inputs presented before it.
    always @(posedge clk) begin
        int cur;
        if (!reset) begin
            kind = 0; hold = 0; done_at = -1;
        end else begin
            cur = m_duty();
            if (abort) begin
                kind = 0; hold = 0; done_at = -1;
            end else if (cmd_valid && !m_ramping()) begin
                case (cmd_mode)
                    M_SET:  begin kind = 0; hold = int'(cmd_target); done_at = cyc + 1; end
                    M_STOP: begin kind = 0; hold = 0; done_at = cyc + 1; end
                    M_RAMP: begin
                        if (cur == int'(cmd_target)) begin
                            kind = 0; hold = cur; done_at = cyc + 1;
                        end else begin
                            kind = 1; t0 = cyc + 1; d0 = cur;
                            tgt = int'(cmd_target); r1 = int'(cmd_rate) + 1;
                        end
                    end
                    default: begin
                        if (cmd_target == 4'd0) begin
                            kind = 0; hold = 0; done_at = -1;
                        end else begin
                            kind = 2; t0 = cyc + 1; d0 = cur;
                            tgt = int'(cmd_target); r1 = int'(cmd_rate) + 1;
                        end
                    end
                endcase
            end
        end
        cyc = cyc + 1;
    end

    task automatic check(input string name, input int got, input int exp);
        total = total + 1;
        if (got != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic send(input logic [1:0] m, input int t, input int r);
        cmd_valid  = 1'b1;
        cmd_mode   = m;
        cmd_target = 4'(t);
        cmd_rate   = 16'(r);
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_mode   = 2'b00;
        cmd_target = 4'd0;
        cmd_rate   = 16'd0;
        abort      = 1'b0;

        // Per-cycle comparison against the model on the falling edge.
        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    check("cyc_duty_rst", int'(duty), 0);
                    check("cyc_busy_rst", int'(busy), 0);
                    check("cyc_done_rst", int'(done), 0);
                    check("cyc_wrap_rst", int'(wrap), 0);
                    check("cyc_ready_rst", int'(cmd_ready), int'(!abort));
                end else begin
                    check("cyc_duty", int'(duty), m_duty());
                    check("cyc_busy", int'(busy), int'(m_busy()));
                    check("cyc_done", int'(done), int'(m_done()));
                    check("cyc_wrap", int'(wrap), int'(m_wrap()));
                    check("cyc_ready", int'(cmd_ready), int'(!m_ramping() && !abort));
                end
            end
        join_none

        repeat (4) begin
            @(posedge clk);
            #2;
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_mode   = 2'($urandom_range(0, 3));
            cmd_target = 4'($urandom_range(0, 15));
            cmd_rate   = 16'($urandom_range(0, 3));
            abort      = 1'($urandom_range(0, 1));
        end
        abort = 1'b0;
        #1;
        check("rst_duty", int'(duty), 0);
        check("rst_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        cmd_valid = 1'b0;
        wait_cyc(1);

        send(M_SET, 9, 0);
        check("set9_duty", int'(duty), 9);
        check("set9_done", int'(done), 1);
        check("set9_busy", int'(busy), 0);
        wait_cyc(1);
        check("set9_done_gone", int'(done), 0);
        send(M_SET, 9, 0);
        check("set9_again_done", int'(done), 1);

        send(M_RAMP, 12, 2);
        check("ramp_ready_low", int'(cmd_ready), 0);
        wait_cyc(3);
        check("ramp_step1", int'(duty), 10);
        cmd_valid = 1'b1; cmd_mode = M_SET; cmd_target = 4'd1;
        wait_cyc(1);
        cmd_valid = 1'b0;
        wait_cyc(2);
        check("ramp_step2", int'(duty), 11);
        wait_cyc(3);
        check("ramp_final", int'(duty), 12);
        check("ramp_done", int'(done), 1);

        send(M_RAMP, 0, 0);
        wait_cyc(11);
        check("ramp_dn_1", int'(duty), 1);
        check("ramp_dn_nodone", int'(done), 0);
        wait_cyc(1);
        check("ramp_dn_0", int'(duty), 0);
        check("ramp_dn_done", int'(done), 1);
        wait_cyc(2);
        check("ramp_dn_hold", int'(duty), 0);

        send(M_BRE, 3, 0);
        wait_cyc(6);
        check("bre3_zero", int'(duty), 0);
        check("bre3_wrap", int'(wrap), 1);
        wait_cyc(3);
        check("bre3_peak", int'(duty), 3);
        send(M_SET, 5, 0);
        check("bre_set5_duty", int'(duty), 5);
        check("bre_set5_done", int'(done), 1);

        send(M_BRE, 2, 1);
        wait_cyc(10);
        check("bre2_zero", int'(duty), 0);
        check("bre2_wrap", int'(wrap), 1);
        wait_cyc(10);

        send(M_BRE, 0, 0);
        check("bre0_duty", int'(duty), 0);
        check("bre0_nodone", int'(done), 0);
        send(M_SET, 7, 0);
        send(M_STOP, 0, 0);
        check("stop_duty", int'(duty), 0);
        check("stop_done", int'(done), 1);

        send(M_RAMP, 15, 0);
        wait_cyc(15);
        check("ramp15_duty", int'(duty), 15);
        check("ramp15_done", int'(done), 1);
        send(M_RAMP, 15, 3);
        check("ramp_eq_done", int'(done), 1);
        check("ramp_eq_busy", int'(busy), 0);

        send(M_SET, 0, 0);
        send(M_RAMP, 12, 1);
        wait_cyc(14);
        check("abort_pre", int'(duty), 7);
        abort = 1'b1;
        cmd_valid = 1'b1; cmd_mode = M_SET; cmd_target = 4'd9;
        #1;
        check("abort_ready", int'(cmd_ready), 0);
        @(posedge clk);
        #1;
        check("abort_duty", int'(duty), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_nodone", int'(done), 0);
        abort = 1'b0;
        cmd_valid = 1'b0;
        wait_cyc(2);
        check("abort_hold", int'(duty), 0);

        send(M_BRE, 4, 0);
        wait_cyc(3);
        check("bre4_mid", int'(duty), 3);
        #2;
        reset = 1'b0;
        #1;
        check("async_duty", int'(duty), 0);
        check("async_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        wait_cyc(4);
        check("post_rst_duty", int'(duty), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
